regfile_writeback: RTL and testbench

- Write-side front end of the LemonPC integer register file.
- Collects completed results from two producers over valid/ready handshakes:
  - the single-cycle ALU path;
  - the multi-cycle LSU/MDU path.
- Arbitrates them onto the register file's single write port (rd / wen / dataD).
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on rs1/rs2, with a one-cycle bypass of the value currently being written.

---
 rtl/lemon_wb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regfile_writeback.sv | 112 +++++++++++
 tb/tb_regfile_writeback.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_wb_pkg.sv
// Shared types and default widths for the LemonPC register-file write-back path.
package lemon_wb_pkg;

  localparam int unsigned DefaultAddrWidth = 5;
  localparam int unsigned DefaultDataWidth = 64;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  function automatic wb_src_e wb_src_other(input wb_src_e src);
    return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on contention the source granted least recently wins.
module rr_arbiter2
  import lemon_wb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  wb_src_e last_q;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (req_alu && req_lsu) begin
      if (wb_src_other(last_q) == WB_SRC_LSU) begin
        gnt_lsu = 1'b1;
      end else begin
        gnt_alu = 1'b1;
      end
    end else begin
      gnt_alu = req_alu;
      gnt_lsu = req_lsu;
    end
  end

  // Reset value marks ALU as last winner so LSU is preferred first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= WB_SRC_ALU;
    end else if (gnt_alu) begin
      last_q <= WB_SRC_ALU;
    end else if (gnt_lsu) begin
      last_q <= WB_SRC_LSU;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: arbitrates ALU/LSU results onto one write port and
// tracks pending writes per register for RAW/WAW hazard detection with one-cycle bypass.
module regfile_writeback
  import lemon_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  input  logic [ADDR_WIDTH-1:0] q_rs1,
  input  logic [ADDR_WIDTH-1:0] q_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs1_byp,
  output logic                  rs2_byp,
  output logic [DATA_WIDTH-1:0] byp_data
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic                  alu_gnt, lsu_gnt;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_rd;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NumRegs-1:0]    busy_q, busy_d;
  logic                  issue_hs;

  // Requests are masked during reset so no ready can be seen while rst_n is low.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (alu_valid & rst_n),
    .req_lsu (lsu_valid & rst_n),
    .gnt_alu (alu_gnt),
    .gnt_lsu (lsu_gnt)
  );

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_comb begin
    wr_rd   = lsu_gnt ? lsu_rd : alu_rd;
    wr_data = lsu_gnt ? lsu_data : alu_data;
    wr_en   = (alu_gnt | lsu_gnt) & (wr_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wen_q <= wr_en;
      if (wr_en) begin
        rd_q   <= wr_rd;
        data_q <= wr_data;
      end
    end
  end

  assign rf_wen   = wen_q;
  assign rf_rd    = rd_q;
  assign rf_dataD = data_q;
  assign byp_data = data_q;

  // A register retiring this cycle may be reissued immediately.
  assign issue_ready = ~(busy_q[issue_rd] & ~(wen_q & (rd_q == issue_rd)));
  assign issue_hs    = issue_valid & issue_ready;

  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_hs && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_byp  = wen_q & (rd_q == q_rs1) & (q_rs1 != '0);
  assign rs2_byp  = wen_q & (rd_q == q_rs2) & (q_rs2 != '0);
  assign rs1_busy = busy_q[q_rs1] & ~rs1_byp;
  assign rs2_busy = busy_q[q_rs2] & ~rs2_byp;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: per-feature tasks with a write-port scoreboard.
module tb_regfile_writeback;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_dataD;
  logic [AW-1:0] q_rs1, q_rs2;
  logic          rs1_busy, rs2_busy, rs1_byp, rs2_byp;
  logic [DW-1:0] byp_data;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_writeback #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .rf_wen      (rf_wen),
    .rf_rd       (rf_rd),
    .rf_dataD    (rf_dataD),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rs1_byp     (rs1_byp),
    .rs2_byp     (rs2_byp),
    .byp_data    (byp_data)
  );

  task automatic push_exp(input logic wen, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    exp_t e;
    e.wen  = wen;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 64'h1234;
    q_rs1     = 5'd3;
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rf_wen, rf_rd, rf_dataD} !== '0) begin
        failures++;
        $display("FAIL rst_wb: got wen=%b rd=%0d data=%h, expected all 0", rf_wen, rf_rd, rf_dataD);
      end
      checks++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0 || rs1_busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_ready: got alu=%b lsu=%b busy=%b, expected 0 0 0",
                 alu_ready, lsu_ready, rs1_busy);
      end
    end
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_issue_ready: got %b expected 1", issue_ready);
    end
    issue_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_release_ready: got alu=%b lsu=%b expected 1 0", alu_ready, lsu_ready);
    end
    exp_q.delete();
    push_exp(1'b1, 5'd3, 64'h1234);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    begin
      exp_t e = exp_q.pop_front();
      checks++;
      if (rf_wen !== e.wen || (e.wen && (rf_rd !== e.rd || rf_dataD !== e.data))) begin
        failures++;
        $display("FAIL rst_first_wb: got wen=%b rd=%0d data=%h, expected wen=%b rd=%0d data=%h",
                 rf_wen, rf_rd, rf_dataD, e.wen, e.rd, e.data);
      end
    end
    push_exp(1'b0, '0, '0);
  endtask

  task automatic test_raw_bypass();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      issue_valid = (c == 0);
      issue_rd    = 5'd5;
      alu_valid   = (c == 1);
      alu_rd      = 5'd5;
      alu_data    = 64'hDEAD;
      q_rs1       = 5'd5;
      q_rs2       = 5'd5;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rf_wen !== e.wen || (e.wen && (rf_rd !== e.rd || rf_dataD !== e.data))) begin
        failures++;
        $display("FAIL raw_wb c%0d: got wen=%b rd=%0d data=%h, expected wen=%b rd=%0d data=%h",
                 c, rf_wen, rf_rd, rf_dataD, e.wen, e.rd, e.data);
      end
      checks++;
      case (c)
        0: if (issue_ready !== 1'b1 || rs1_busy !== 1'b0) begin
          failures++;
          $display("FAIL raw_issue: got ready=%b busy=%b expected 1 0", issue_ready, rs1_busy);
        end
        1: if (rs1_busy !== 1'b1 || rs1_byp !== 1'b0 || alu_ready !== 1'b1) begin
          failures++;
          $display("FAIL raw_pending: got busy=%b byp=%b ready=%b expected 1 0 1",
                   rs1_busy, rs1_byp, alu_ready);
        end
        2: if (rs1_byp !== 1'b1 || rs2_byp !== 1'b1 || rs1_busy !== 1'b0
               || byp_data !== 64'hDEAD) begin
          failures++;
          $display("FAIL raw_bypass: got byp=%b/%b busy=%b data=%h expected 1/1 0 dead",
                   rs1_byp, rs2_byp, rs1_busy, byp_data);
        end
        default: if (rs1_byp !== 1'b0 || rs1_busy !== 1'b0) begin
          failures++;
          $display("FAIL raw_after: got byp=%b busy=%b expected 0 0", rs1_byp, rs1_busy);
        end
      endcase
      if (c == 1) push_exp(1'b1, 5'd5, 64'hDEAD);
      else        push_exp(1'b0, '0, '0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   li = 0;
    int   ai = 0;
    logic exp_lsu;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      lsu_valid = (c < 5) && (li < 3);
      lsu_rd    = AW'(2 * li + 1);
      lsu_data  = 64'h1500_0000_0000_0000 + 64'(2 * li + 1);
      alu_valid = (c < 5) && (ai < 2);
      alu_rd    = AW'(2 * ai + 2);
      alu_data  = 64'hA100_0000_0000_0000 + 64'(2 * ai + 2);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rf_wen !== e.wen || (e.wen && (rf_rd !== e.rd || rf_dataD !== e.data))) begin
        failures++;
        $display("FAIL b2b_wb c%0d: got wen=%b rd=%0d data=%h, expected wen=%b rd=%0d data=%h",
                 c, rf_wen, rf_rd, rf_dataD, e.wen, e.rd, e.data);
      end
      if (c < 5) begin
        exp_lsu = (c % 2 == 0);
        checks++;
        if (lsu_ready !== exp_lsu || alu_ready !== !exp_lsu) begin
          failures++;
          $display("FAIL b2b_grant c%0d: got lsu=%b alu=%b expected lsu=%b alu=%b",
                   c, lsu_ready, alu_ready, exp_lsu, !exp_lsu);
        end
        if (exp_lsu) begin
          push_exp(1'b1, lsu_rd, lsu_data);
          li++;
        end else begin
          push_exp(1'b1, alu_rd, alu_data);
          ai++;
        end
      end else begin
        push_exp(1'b0, '0, '0);
      end
    end
  endtask

  task automatic test_x0();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      alu_valid   = (c == 0);
      alu_rd      = '0;
      alu_data    = 64'hFFFF;
      issue_valid = (c == 0);
      issue_rd    = '0;
      q_rs1       = '0;
      q_rs2       = 5'd5;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rf_wen !== e.wen || (e.wen && (rf_rd !== e.rd || rf_dataD !== e.data))) begin
        failures++;
        $display("FAIL x0_wb c%0d: got wen=%b rd=%0d data=%h, expected wen=%b",
                 c, rf_wen, rf_rd, rf_dataD, e.wen);
      end
      checks++;
      if (c == 0) begin
        if (alu_ready !== 1'b1 || issue_ready !== 1'b1) begin
          failures++;
          $display("FAIL x0_ready: got alu=%b issue=%b expected 1 1", alu_ready, issue_ready);
        end
      end else if (rs1_busy !== 1'b0 || rs1_byp !== 1'b0 || rs2_busy !== 1'b0) begin
        failures++;
        $display("FAIL x0_sb: got busy=%b byp=%b busy5=%b expected 0 0 0",
                 rs1_busy, rs1_byp, rs2_busy);
      end
      push_exp(1'b0, '0, '0);
    end
  endtask

  task automatic test_waw();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      issue_valid = (c < 3);
      issue_rd    = 5'd7;
      alu_valid   = (c == 1);
      alu_rd      = 5'd7;
      alu_data    = 64'h77;
      q_rs1       = 5'd7;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rf_wen !== e.wen || (e.wen && (rf_rd !== e.rd || rf_dataD !== e.data))) begin
        failures++;
        $display("FAIL waw_wb c%0d: got wen=%b rd=%0d data=%h, expected wen=%b rd=%0d data=%h",
                 c, rf_wen, rf_rd, rf_dataD, e.wen, e.rd, e.data);
      end
      checks++;
      case (c)
        0: if (issue_ready !== 1'b1) begin
          failures++;
          $display("FAIL waw_first_issue: got %b expected 1", issue_ready);
        end
        1: if (issue_ready !== 1'b0) begin
          failures++;
          $display("FAIL waw_stall: got %b expected 0", issue_ready);
        end
        2: if (issue_ready !== 1'b1) begin
          failures++;
          $display("FAIL waw_retire_reissue: got %b expected 1", issue_ready);
        end
        default: if (rs1_busy !== 1'b1) begin
          failures++;
          $display("FAIL waw_set_wins: got busy=%b expected 1", rs1_busy);
        end
      endcase
      if (c == 1) push_exp(1'b1, 5'd7, 64'h77);
      else        push_exp(1'b0, '0, '0);
    end
  endtask

  task automatic test_reset_inflight();
    exp_t                e;
    logic [(1<<AW)-1:0]  seen;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd12;
    lsu_data    = 64'hC0FFEE;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rf_wen !== e.wen) begin
      failures++;
      $display("FAIL flush_pre_wb: got wen=%b expected %b", rf_wen, e.wen);
    end
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_lsu_ready: got %b expected 1", lsu_ready);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      lsu_valid   = 1'b0;
      if (c == 2) rst_n = 1'b1;
      #1;
      checks++;
      if (rf_wen !== 1'b0) begin
        failures++;
        $display("FAIL flush_wb c%0d: got wen=%b expected 0", c, rf_wen);
      end
    end
    seen = '0;
    for (int r = 0; r < (1 << AW); r++) begin
      q_rs1 = AW'(r);
      q_rs2 = AW'(r);
      #1;
      seen[r] = rs1_busy | rs2_busy;
    end
    checks++;
    if (seen !== '0) begin
      failures++;
      $display("FAIL flush_busy: got busy mask=%h expected 0", seen);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    q_rs1       = '0;
    q_rs2       = '0;
    test_reset();
    test_raw_bypass();
    test_back_to_back();
    test_x0();
    test_waw();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
